// File: rtl/uart_pkg.sv
// Shared types and helpers for the FIFO-fed UART transmitter.
package uart_pkg;

  // Frame sequencer states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATAIN = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  // Widest data word the transmitter supports.
  localparam int MAX_DATA_W = 9;

  // Parity over a zero-extended word; zero padding does not change the XOR.
  function automatic logic calc_parity(input logic [MAX_DATA_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data and an occupancy count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     nRst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage array; contents need no reset since the count guards every read.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO: LSB-first data, optional parity,
// one or two stop bits, consecutive queued words sent with no idle gap.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_W       = 8,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              tx_ctrl,
  input  logic [DATA_W-1:0] tx_byte,
  output logic              transmit_ready,
  output logic              tx_serial,
  output logic              tx_busy,
  output logic              overflow
);

  localparam int BW  = $clog2(CLKS_PER_BIT);
  localparam int CW  = $clog2(DATA_W + 1);
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  uart_state_t       state;
  logic [BW-1:0]     baud_cnt;
  logic [CW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shift_reg;
  logic              parity_bit;

  logic              fifo_full;
  logic              fifo_empty;
  logic [FCW-1:0]    fifo_count;
  logic [DATA_W-1:0] fifo_data;
  logic              wr_en;
  logic              rd_en;
  logic              baud_end;
  logic              last_data;
  logic              last_stop;
  logic              next_parity;

  // Handshake: a word is taken on any cycle where tx_ctrl && transmit_ready;
  // transmit_ready depends only on the registered count, never on a same-cycle pop.
  assign transmit_ready = !fifo_full;
  assign wr_en          = tx_ctrl && transmit_ready;
  assign baud_end       = (baud_cnt == BW'(CLKS_PER_BIT - 1));
  assign last_data      = (bit_cnt == CW'(DATA_W - 1));
  assign last_stop      = (bit_cnt == CW'(STOP_BITS - 1));
  assign rd_en          = !fifo_empty &&
                          ((state == IDLE) || ((state == STOP) && baud_end && last_stop));
  assign next_parity    = calc_parity(MAX_DATA_W'(fifo_data), PARITY_ODD != 0);
  assign tx_busy        = (state != IDLE) || (fifo_count != '0);

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .nRst    (nRst),
    .wr_en   (wr_en),
    .wr_data (tx_byte),
    .rd_en   (rd_en),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Frame sequencer: bit timing, data shifting and word loading.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (rd_en) begin
            shift_reg  <= fifo_data;
            parity_bit <= next_parity;
            state      <= START;
          end
        end
        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= DATAIN;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        DATAIN: begin
          if (baud_end) begin
            baud_cnt  <= '0;
            shift_reg <= shift_reg >> 1;
            if (last_data) begin
              bit_cnt <= '0;
              state   <= (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        PARITY: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (last_stop) begin
              bit_cnt <= '0;
              if (rd_en) begin
                shift_reg  <= fifo_data;
                parity_bit <= next_parity;
                state      <= START;
              end else begin
                state <= IDLE;
              end
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered line driver: one cycle behind the sequencer, so a word loaded
  // at edge N+1 puts its start bit on the line at edge N+2; idle level is high.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      tx_serial <= 1'b1;
    end else begin
      case (state)
        START:   tx_serial <= 1'b0;
        DATAIN:  tx_serial <= shift_reg[0];
        PARITY:  tx_serial <= parity_bit;
        default: tx_serial <= 1'b1;
      endcase
    end
  end

  // Dropped-write indicator, one cycle wide per rejected strobe.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) overflow <= 1'b0;
    else       overflow <= tx_ctrl && !transmit_ready;
  end

endmodule
